// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: requester-side and cache-side signals of the two-port cache arbiter.
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              req0, req1, rwb0, rwb1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              done0, done1, err;
    logic [DATA_W-1:0] rdata;
    logic              c_req, c_rwb, c_ack;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;

    modport master (
        output req0, req1, rwb0, rwb1, addr0, addr1, wdata0, wdata1, c_ack, c_rdata,
        input  done0, done1, err, rdata, c_req, c_rwb, c_addr, c_wdata
    );

    modport slave (
        input  req0, req1, rwb0, rwb1, addr0, addr1, wdata0, wdata1, c_ack, c_rdata,
        output done0, done1, err, rdata, c_req, c_rwb, c_addr, c_wdata
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin two-port arbiter issuing one registered cache request at a time.
// Define ARB_TIMEOUT_EN to abort REQ after TIMEOUT cycles without c_ack (err = 1 in DONE).
module cache_port_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d, prio_q, prio_d;
    logic              c_req_q, c_req_d, c_rwb_q, c_rwb_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_wdata_q, c_wdata_d, rdata_q, rdata_d;
    logic              pick, tmo;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    assign tmo     = cnt_q == 8'(TIMEOUT - 1);
    assign bus.err = err_q;
`else
    assign tmo     = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign pick      = (bus.req0 & bus.req1) ? prio_q : bus.req1;
    assign bus.c_req   = c_req_q;
    assign bus.c_rwb   = c_rwb_q;
    assign bus.c_addr  = c_addr_q;
    assign bus.c_wdata = c_wdata_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.rdata   = rdata_q;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        prio_d    = prio_q;
        c_req_d   = c_req_q;
        c_rwb_d   = c_rwb_q;
        c_addr_d  = c_addr_q;
        c_wdata_d = c_wdata_q;
        rdata_d   = rdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: if (bus.req0 | bus.req1) begin
                win_d     = pick;
                c_rwb_d   = pick ? bus.rwb1 : bus.rwb0;
                c_addr_d  = pick ? bus.addr1 : bus.addr0;
                c_wdata_d = pick ? bus.wdata1 : bus.wdata0;
                c_req_d   = 1'b1;
                state_d   = REQ;
`ifdef ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            REQ: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
                err_d = tmo & ~bus.c_ack;
`endif
                // an ack in the expiry cycle still completes the transfer normally
                if (bus.c_ack | tmo) begin
                    rdata_d = bus.c_ack ? (c_rwb_q ? bus.c_rdata : rdata_q) : '0;
                    c_req_d = 1'b0;
                    done0_d = ~win_q;
                    done1_d = win_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                prio_d  = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            prio_q    <= 1'b0;
            c_req_q   <= 1'b0;
            c_rwb_q   <= 1'b1;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
            rdata_q   <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            prio_q    <= prio_d;
            c_req_q   <= c_req_d;
            c_rwb_q   <= c_rwb_d;
            c_addr_q  <= c_addr_d;
            c_wdata_q <= c_wdata_d;
            rdata_q   <= rdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
`ifdef ARB_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: randomized rounds against a round-robin reference model with a done-pulse scoreboard.
// Directed timeout cases run only when ARB_TIMEOUT_EN is defined.
module tb_cache_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit          port;
        bit          rwb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] crd;
        int          dly;
        logic [DW-1:0] exp_rdata;
        bit          exp_err;
    } txn_t;

    txn_t cache_q[$];
    txn_t exp_q[$];
    int errors = 0;
    int checks = 0;
    bit prio = 1'b0;
    logic [DW-1:0] last_rd = '0;

    txn_t r_cur, m_e, t_rst;
    bit   r_active = 1'b0;
    int   r_cnt = 0, r_hi = 0, sel = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(bit port, bit rwb, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                                logic [DW-1:0] crd, int dly);
        txn_t t;
        t.port = port; t.rwb = rwb; t.addr = addr; t.wdata = wdata; t.crd = crd; t.dly = dly;
        t.exp_rdata = '0; t.exp_err = 1'b0;
        return t;
    endfunction

    function automatic txn_t rnd(bit port);
        return mk(port, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(0, 5));
    endfunction

    // reference: a negative delay means the cache never answers (timeout abort)
    task automatic model(input txn_t t);
        t.exp_err   = t.dly < 0;
        t.exp_rdata = t.exp_err ? '0 : (t.rwb ? t.crd : last_rd);
        last_rd     = t.exp_rdata;
        prio        = ~t.port;
        cache_q.push_back(t);
        exp_q.push_back(t);
    endtask

    task automatic drive(input txn_t t);
        if (t.port) begin
            bus.req1 = 1'b1; bus.rwb1 = t.rwb; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
        end else begin
            bus.req0 = 1'b1; bus.rwb0 = t.rwb; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
        end
    endtask

    task automatic wait_done(bit u0, bit u1);
        bit p0 = u0, p1 = u1, f0 = 1'b0, f1 = 1'b0;
        for (int n = 0; n < 200 && (p0 || p1); n++) begin
            @(negedge clk);
            f0 = p0 && bus.done0;
            f1 = p1 && bus.done1;
            @(posedge clk);
            #1;
            if (f0) begin bus.req0 = 1'b0; p0 = 1'b0; end
            if (f1) begin bus.req1 = 1'b0; p1 = 1'b0; end
        end
        if (p0 || p1) begin
            errors++;
            checks++;
            $display("FAIL round_timeout: pending port0=%0d port1=%0d, required none", p0, p1);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
    endtask

    task automatic do_round(bit u0, bit u1, input txn_t t0, input txn_t t1);
        if (u0 && u1) begin
            if (prio) begin model(t1); model(t0); end
            else begin model(t0); model(t1); end
        end else if (u0) model(t0);
        else model(t1);
        if (u0) drive(t0);
        if (u1) drive(t1);
        wait_done(u0, u1);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_c_req"}, 32'(bus.c_req), 32'd0);
        chk({tag, "_c_rwb"}, 32'(bus.c_rwb), 32'd1);
        chk({tag, "_c_addr"}, 32'(bus.c_addr), 32'd0);
        chk({tag, "_c_wdata"}, 32'(bus.c_wdata), 32'd0);
        chk({tag, "_done"}, 32'({bus.done1, bus.done0}), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    // cache responder: checks the request fields and answers after each transaction's delay
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            r_active  = 1'b0;
            bus.c_ack = 1'b0;
        end else begin
            if (bus.c_req && !r_active) begin
                if (cache_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_c_req: c_addr=%0h with no transaction queued", bus.c_addr);
                end else begin
                    r_cur = cache_q.pop_front();
                    r_active = 1'b1;
                    r_hi = 0;
                    r_cnt = r_cur.dly;
                end
            end
            if (r_active && bus.c_req) begin
                r_hi++;
                chk("c_fields", 32'({bus.c_rwb, bus.c_addr, bus.c_wdata}),
                    32'({r_cur.rwb, r_cur.addr, r_cur.wdata}));
                bus.c_ack   = r_cnt == 0;
                bus.c_rdata = r_cnt == 0 ? r_cur.crd : DW'($urandom);
                r_cnt--;
            end else if (r_active) begin
                chk("c_req_cycles", 32'(r_hi), 32'(r_cur.dly < 0 ? TO : r_cur.dly + 1));
                chk("done_after_ack", 32'(bus.done0 | bus.done1), 32'd1);
                r_active    = 1'b0;
                bus.c_ack   = 1'($urandom);
                bus.c_rdata = DW'($urandom);
            end else begin
                bus.c_ack   = 1'($urandom);
                bus.c_rdata = DW'($urandom);
            end
        end
    end

    // scoreboard monitor: every done pulse consumes one expected completion
    initial forever begin
        @(negedge clk);
        if (rst_n && (bus.done0 || bus.done1)) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL spurious_done: done1=%0d done0=%0d with nothing outstanding", bus.done1, bus.done0);
            end else begin
                m_e = exp_q.pop_front();
                chk("done_port", 32'({bus.done1, bus.done0}), m_e.port ? 32'd2 : 32'd1);
                chk("rdata", 32'(bus.rdata), 32'(m_e.exp_rdata));
                chk("err", 32'(bus.err), 32'(m_e.exp_err));
            end
        end
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rwb0 = 1'b1; bus.rwb1 = 1'b1;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.c_ack = 1'b0; bus.c_rdata = '0;
        #3 rst_n = 1'b0;
        #1 chk_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_round(1, 0, mk(0, 1, 6'h21, 8'h00, 8'hA5, 0), mk(1, 0, 6'h00, 8'h00, 8'h00, 0));
        do_round(0, 1, mk(0, 0, 6'h00, 8'h00, 8'h00, 0), mk(1, 1, 6'h0C, 8'h11, 8'h5E, 4));
        repeat (2) do_round(1, 1, mk(0, 0, 6'h05, 8'h3C, 8'h00, 0), mk(1, 0, 6'h2A, 8'hC3, 8'h00, 1));
        repeat (40) begin
            sel = $urandom_range(1, 3);
            do_round(sel[0], sel[1], rnd(0), rnd(1));
        end
        do_round(1, 0, mk(0, 1, 6'h10, 8'h00, 8'h6B, 0), mk(1, 0, 6'h00, 8'h00, 8'h00, 0));
        t_rst = mk(0, 1, 6'h3F, 8'hFF, 8'h99, 10);
        cache_q.push_back(t_rst);
        drive(t_rst);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        bus.req0 = 1'b0;
        prio = 1'b0;
        last_rd = '0;
        cache_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_round(1, 1, rnd(0), rnd(1));
`ifdef ARB_TIMEOUT_EN
        do_round(1, 0, mk(0, 1, 6'h11, 8'h00, 8'h77, -1), mk(1, 0, 6'h00, 8'h00, 8'h00, 0));
        do_round(0, 1, mk(0, 0, 6'h00, 8'h00, 8'h00, 0), mk(1, 1, 6'h12, 8'h00, 8'h5A, TO - 1));
`endif
        repeat (5) @(posedge clk);
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester arbiter and sequencer in front of the cache.

- Accepts read/write requests from two processor-style requesters. Each requester presents RWB (1 = read, 0 = write), a 6-bit address and 8-bit data.
- Grants one requester at a time using round-robin priority and drives a single request/acknowledge transaction into the cache.
- Returns read data and a one-cycle completion pulse to the winning requester.

## Interface
- ADDR_W, 6, address width
- DATA_W, 8, data width
- TIMEOUT, 15, maximum cycles in REQ before abort; valid range 1..255; used only with ARB_TIMEOUT_EN
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  request from port 0 / 1; held high until that port's done is sampled
- rwb0, rwb1  in  1  1 = read, 0 = write; stable while req is high
- addr0, addr1  in  ADDR_W  request address; stable while req is high
- wdata0, wdata1  in  DATA_W  write data; stable while req is high
- done0, done1  out  1  one-cycle completion pulse to port 0 / 1
- rdata  out  DATA_W  read data; valid in the done cycle
- err  out  1  timeout abort flag; valid in the done cycle
- c_req  out  1  request to the cache
- c_rwb  out  1  RWB to the cache
- c_addr  out  ADDR_W  address to the cache
- c_wdata  out  DATA_W  write data to the cache
- c_ack  in  1  cache completion; sampled only in REQ
- c_rdata  in  DATA_W  cache read data; sampled with c_ack

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE:
  - If either req is high, select the winner.
  - Latch the winner's rwb, addr and wdata into c_rwb, c_addr and c_wdata.
  - Record the winner index and go to REQ.
  - If neither req is high, stay in IDLE.
- Winner selection:
  - A single requester always wins.
  - If both request, the port selected by the prio bit wins.
- REQ:
  - c_req = 1 and the c_* fields are held.
  - When c_ack is sampled high: if c_rwb = 1, capture c_rdata into rdata; then go to DONE.
  - For writes, rdata keeps its previous value.
- DONE:
  - c_req = 0 and err = 0 (unless a timeout aborted the transaction).
  - done_winner = 1 for exactly one cycle.
  - prio is set to the other port.
  - Next state is IDLE.
- Requester rule: the requester deasserts req at the edge where it samples done high. A req seen high in IDLE is always treated as a new request.
- c_ack is ignored in IDLE and DONE.
- req toggling on the non-winning port has no effect until the next IDLE.
- Reset values: c_req 0, c_rwb 1, c_addr 0, c_wdata 0, done0/done1 0, rdata 0, err 0, prio 0 (port 0 wins the first tie), timeout counter 0.
- Reset mid-transaction: rst_n low forces every output and register to its reset value immediately, and c_req drops asynchronously. No done pulse is issued for the aborted transaction.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: REQ, c_req high, fields valid.
- Cycle k: the cycle in which c_ack is sampled high (k ≥ 1).
- Cycle k+1: DONE, done pulse, rdata valid.
- Cycle k+2: IDLE.
- Minimum req-to-done latency is 2 cycles (c_ack high in cycle 1).
- Back-to-back throughput is one transaction per 3 cycles plus cache wait.
- If both ports hold req continuously, grants alternate 0,1,0,1… No port waits more than one transaction.
- All outputs are registered; there is no combinational path from req or c_ack to any output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter increments each cycle in REQ.
  - When the counter reaches TIMEOUT with c_ack still low: drop c_req, go to DONE with err = 1 and rdata = 0, and update prio normally.
  - The counter clears on entry to REQ.
  - If c_ack arrives in the same cycle the counter reaches TIMEOUT, c_ack wins and err = 0.
- ARB_TIMEOUT_EN undefined:
  - REQ waits indefinitely.
  - err is tied 0.
  - The counter logic is absent.

## Test plan
- Reset, then req0 read of addr 6'h21 with c_ack in cycle 1 and c_rdata 8'hA5 -> c_req high in cycle 1, done0 in cycle 2, rdata = 8'hA5, done1 never asserted.
- req0 and req1 both held for four transactions, each a write (addr0 = 6'h05, wdata0 = 8'h3C; addr1 = 6'h2A, wdata1 = 8'hC3) -> c_addr sequence 05, 2A, 05, 2A; done pulses alternate 0,1,0,1; rdata unchanged.
- req1 read with c_ack delayed 5 cycles -> c_req high for exactly 5 cycles, done1 in cycle 6, c_addr and c_rwb stable throughout.
- rst_n low in the second REQ cycle -> all outputs at reset values in the same cycle; after release, a tie between req0 and req1 is granted to port 0.
- With ARB_TIMEOUT_EN and TIMEOUT = 15, c_ack never asserted -> c_req high for 15 cycles, then a done pulse with err = 1 and rdata = 0. Repeat with c_ack in the 15th cycle -> err = 0.
